// File: rtl/harris_pkg.sv
// Shared types for the Harris corner pipeline: pixel width, window size and
// the window array handed from window_gen to the gradient stage.
package harris_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_N = 6;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [0:WIN_N-1][0:WIN_N-1] win_t;
endpackage

// File: rtl/window_gen_if.sv
// Pixel stream in, 6x6 window stream out. master = pixel source side,
// slave = window_gen side.
interface window_gen_if;
  import harris_pkg::*;

  logic        pix_valid;
  pix_t        pix_in;
  win_t        window;
  logic        win_valid;
  logic [63:0] count;
  logic        frame_done;

  modport master (output pix_valid, pix_in,
                  input  window, win_valid, count, frame_done);
  modport slave  (input  pix_valid, pix_in,
                  output window, win_valid, count, frame_done);
endinterface

// File: rtl/line_buffer.sv
// One image row of delay: dout is the pixel written DEPTH enables ago,
// read combinationally before the same-cycle write overwrites it.
module line_buffer
  import harris_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t          mem [0:DEPTH-1];
  logic [AW-1:0] ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == AW'(DEPTH-1)) ? '0 : ptr + 1'b1;
  end

  // Contents are never cleared; stale data is masked by window gating.
  always_ff @(posedge clk) begin
    if (en)
      mem[ptr] <= din;
  end
endmodule

// File: rtl/window_gen.sv
// Raster-scan 6x6 sliding window generator: five cascaded line buffers feed
// a 6x6 shift register; windows are flagged only when fully inside a frame.
module window_gen
  import harris_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input logic         clk,
  input logic         reset,
  window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept, last_col, last_row, in_win;
  pix_t          tap [0:WIN_N-1];
  win_t          win_q;
  logic          vld_q, done_q;
  logic [63:0]   cnt_q;

  assign accept   = bus.pix_valid;
  assign last_col = (col == CW'(IMG_W-1));
  assign last_row = (row == RW'(IMG_H-1));
  assign in_win   = (row >= RW'(WIN_N-1)) && (col >= CW'(WIN_N-1));

  // tap[k] is the pixel k rows above the incoming one, same column.
  assign tap[0] = bus.pix_in;

  generate
    for (genvar k = 1; k < WIN_N; k++) begin : g_lb
      line_buffer #(.DEPTH(IMG_W)) u_lb (
        .clk  (clk),
        .reset(reset),
        .en   (accept && !reset),
        .din  (tap[k-1]),
        .dout (tap[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < WIN_N; i++) begin
        for (int j = 0; j < WIN_N-1; j++)
          win_q[i][j] <= win_q[i][j+1];
        win_q[i][WIN_N-1] <= tap[WIN_N-1-i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= accept && in_win;
      done_q <= accept && in_win && last_row && last_col;
      if (accept && in_win)
        cnt_q <= 64'(row) * 64'(IMG_W) + 64'(col);
    end
  end

  assign bus.window     = win_q;
  assign bus.win_valid  = vld_q;
  assign bus.frame_done = done_q;
  assign bus.count      = cnt_q;
endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on an 8x8 image with pix_in = raster index.
module tb_window_gen;
  import harris_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_gen_if bus ();

  window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_count;
  win_t        exp_win;
  bit          win_known;

  task automatic step(input logic rst, input logic v, input logic [7:0] p);
    @(negedge clk);
    reset         = rst;
    bus.pix_valid = v;
    bus.pix_in    = p;
    @(posedge clk);
    #1;
  endtask

  // window[i][j] = pixel (r-5+i, c-5+j), plus a per-frame value offset
  function automatic win_t model_win(input int idx, input int off);
    win_t w;
    int r, c;
    r = idx / W;
    c = idx % W;
    for (int i = 0; i < WIN_N; i++)
      for (int j = 0; j < WIN_N; j++)
        w[i][j] = 8'((r-5+i)*W + (c-5+j) + off);
    return w;
  endfunction

  task automatic run_frame(input string tag, input int off, input int stall_at,
                           input int stall_len, input bit rnd, output int nwin);
    int  idle, r, c;
    bit  ev, ed;
    nwin = 0;
    for (int idx = 0; idx < W*H; idx++) begin
      idle = (idx == stall_at) ? stall_len : 0;
      if (rnd)
        while (idle < 8 && $urandom_range(1, 0) == 0) idle++;
      repeat (idle) begin
        step(1'b0, 1'b0, 8'($urandom));
        total++;
        if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
          bad++;
          $display("FAIL %s stall_flags idx=%0d got v=%0b d=%0b exp 0 0",
                   tag, idx, bus.win_valid, bus.frame_done);
        end
        total++;
        if (bus.count !== exp_count) begin
          bad++;
          $display("FAIL %s stall_count idx=%0d got=%0d exp=%0d", tag, idx, bus.count, exp_count);
        end
        if (win_known) begin
          total++;
          if (bus.window !== exp_win) begin
            bad++;
            $display("FAIL %s stall_window idx=%0d got=%h exp=%h", tag, idx, bus.window, exp_win);
          end
        end
      end

      step(1'b0, 1'b1, 8'(idx + off));
      r  = idx / W;
      c  = idx % W;
      ev = (r >= 5) && (c >= 5);
      ed = ev && (idx == W*H-1);
      if (idx >= 45) begin
        exp_win   = model_win(idx, off);
        win_known = 1'b1;
      end else begin
        win_known = 1'b0;
      end

      total++;
      if (bus.win_valid !== ev) begin
        bad++;
        $display("FAIL %s win_valid idx=%0d got=%0b exp=%0b", tag, idx, bus.win_valid, ev);
      end
      total++;
      if (bus.frame_done !== ed) begin
        bad++;
        $display("FAIL %s frame_done idx=%0d got=%0b exp=%0b", tag, idx, bus.frame_done, ed);
      end
      if (ev) begin
        nwin++;
        exp_count = 64'(idx);
        total++;
        if (bus.count !== exp_count) begin
          bad++;
          $display("FAIL %s count idx=%0d got=%0d exp=%0d", tag, idx, bus.count, exp_count);
        end
        total++;
        if (bus.window !== exp_win) begin
          bad++;
          $display("FAIL %s window idx=%0d got=%h exp=%h", tag, idx, bus.window, exp_win);
        end
      end
      if (idx == 45) begin
        total++;
        if (bus.window[0][0] !== 8'(0 + off) || bus.window[5][5] !== 8'(45 + off) ||
            bus.window[0][5] !== 8'(5 + off) || bus.window[5][0] !== 8'(40 + off)) begin
          bad++;
          $display("FAIL %s corners got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d", tag,
                   bus.window[0][0], bus.window[5][5], bus.window[0][5], bus.window[5][0],
                   8'(off), 8'(45 + off), 8'(5 + off), 8'(40 + off));
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.count !== 64'd0 || bus.window !== '0) begin
      bad++;
      $display("FAIL %s reset_outputs got v=%0b d=%0b cnt=%0d win=%h exp all 0",
               tag, bus.win_valid, bus.frame_done, bus.count, bus.window);
    end
  endtask

  task automatic test_reset();
    // pix_valid high during reset must be ignored
    step(1'b1, 1'b1, 8'hAA);
    check_reset_outputs("reset_c1");
    step(1'b1, 1'b1, 8'h55);
    check_reset_outputs("reset_c2");
    exp_count = '0;
    exp_win   = '0;
    win_known = 1'b1;
  endtask

  task automatic test_single_frame();
    int n;
    run_frame("frame", 0, -1, 0, 1'b0, n);
    total++;
    if (n !== 9) begin
      bad++;
      $display("FAIL frame num_windows got=%0d exp=9", n);
    end
  endtask

  task automatic test_stall();
    int n;
    run_frame("stall", 0, 51, 3, 1'b0, n);
    total++;
    if (n !== 9) begin
      bad++;
      $display("FAIL stall num_windows got=%0d exp=9", n);
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1, n2;
    run_frame("b2b_f1", 0, -1, 0, 1'b0, n0);
    run_frame("b2b_f2", 0, -1, 0, 1'b0, n1);
    run_frame("b2b_f3", 128, -1, 0, 1'b0, n2);
    total++;
    if (n0 !== 9 || n1 !== 9 || n2 !== 9) begin
      bad++;
      $display("FAIL b2b num_windows got=%0d,%0d,%0d exp=9,9,9", n0, n1, n2);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    for (int idx = 0; idx <= 30; idx++)
      step(1'b0, 1'b1, 8'(idx + 77));
    step(1'b1, 1'b1, 8'hFF);
    check_reset_outputs("midrst_c1");
    step(1'b1, 1'b0, 8'h00);
    check_reset_outputs("midrst_c2");
    exp_count = '0;
    exp_win   = '0;
    win_known = 1'b1;
    run_frame("after_rst", 0, -1, 0, 1'b0, n);
    total++;
    if (n !== 9) begin
      bad++;
      $display("FAIL after_rst num_windows got=%0d exp=9", n);
    end
  endtask

  task automatic test_random_valid();
    int n, sum;
    sum = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame("random", 0, -1, 0, 1'b1, n);
      sum += n;
    end
    total++;
    if (sum !== 27) begin
      bad++;
      $display("FAIL random num_windows got=%0d exp=27", sum);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    exp_count     = '0;
    exp_win       = '0;
    win_known     = 1'b1;

    test_reset();
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    test_random_valid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
